// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, register offsets and STATUS bit positions
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIVISOR = 2'd2;
  localparam int ST_FULL = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_ACTIVE = 2;
  localparam int ST_OVF = 3;
  localparam int ST_CNT = 8;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head and push-while-full only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with TX FIFO and programmable bit period
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        hit,
  output logic [31:0] rd_data,
  output logic        tx,
  output logic        tx_busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state;
  logic [1:0] off;
  logic we, push, pop, full, empty, overflow;
  logic [7:0] head, sh;
  logic [CW-1:0] count;
  logic [15:0] divisor, div_l, cnt;
  logic [2:0] idx;
  logic [31:0] status;
  assign hit = addr[31:4] == BASE_ADDR[31:4];
  assign off = addr[3:2];
  assign we = hit & wr_en;
  assign push = we & (off == OFF_TXDATA);
  assign pop = ~empty & (state == IDLE | (state == STOP & cnt == '0));
  assign tx_busy = ~empty | (state != IDLE);
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(wr_data[7:0]),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_comb begin
    status = '0;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_ACTIVE] = state != IDLE;
    status[ST_OVF] = overflow;
    status[ST_CNT +: 8] = 8'(count);
    rd_data = !hit ? 32'b0 : off == OFF_STATUS ? status : off == OFF_DIVISOR ? {16'b0, divisor} : 32'b0;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      divisor <= DIV_RESET;
      overflow <= 1'b0;
    end else begin
      if (we & off == OFF_DIVISOR) divisor <= wr_data[15:0] == '0 ? 16'd1 : wr_data[15:0];
      if (push & full & ~pop) overflow <= 1'b1;
      else if (we & off == OFF_STATUS & wr_data[ST_OVF]) overflow <= 1'b0;
    end
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      div_l <= '0;
      sh <= '0;
      idx <= '0;
      tx <= 1'b1;
    end else begin
      tx <= state == START ? 1'b0 : state == DATA ? sh[idx] : 1'b1;
      if (pop) begin
        sh <= head;
        div_l <= divisor;
        cnt <= divisor;
        idx <= '0;
        state <= START;
      end else if (state != IDLE) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        else begin
          cnt <= div_l;
          if (state == START) state <= DATA;
          else if (state == DATA) begin
            idx <= idx + 1'b1;
            if (idx == 3'd7) state <= STOP;
          end else state <= IDLE;
        end
      end
    end
endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the single-cycle core's data bus, downstream of the core's data-memory port. Decodes its 16-byte window from the core's address/write-enable/write-data and returns read data combinationally in the same cycle, as the single-cycle core requires. Buffers bytes in a small FIFO and serializes them 8N1, LSB first, at a programmable bit period.

## Interface
- BASE_ADDR, 32'h8000_0000: window base, 16-byte aligned; bits [3:0] ignored.
- FIFO_DEPTH, 8: TX FIFO entries; power of two, ≥ 2.
- DIV_RESET, 16'd433: reset value of DIVISOR; bit period = DIVISOR+1 clocks.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-low; state resets on a rising clk edge with reset==0.
- addr  in  32  byte address from the core's ALU_result.
- wr_en  in  1  store strobe from the core's dmem_wren.
- wr_data  in  32  store data from the core's dmem_data_in.
- hit  out  1  addr[31:4]==BASE_ADDR[31:4]; combinational.
- rd_data  out  32  register read data; combinational; 0 when !hit.
- tx  out  1  serial line; idle high.
- tx_busy  out  1  FIFO non-empty or serializer not IDLE.

## Operation
- Register map, offset = addr[3:2]:
  - 0 TXDATA: write pushes wr_data[7:0]. Reads 0.
  - 1 STATUS: reads {count[..], 24'b0-padded, bit3 overflow, bit2 tx_active, bit1 empty, bit0 full}. count sits in bits [15:8]. Writing 1 to bit3 clears overflow.
  - 2 DIVISOR: rw, bits [15:0]. A written value of 0 stores 1. Upper bits read 0.
  - 3: reserved. Reads 0, writes ignored.
- A write acts only when hit & wr_en. Byte offset addr[1:0] is ignored.
- Push when full: byte dropped, overflow set (sticky).
- Push in the same cycle as a pop while full: accepted; count unchanged.
- Serializer FSM:
  - IDLE: tx=1. If FIFO non-empty, pop the head, latch the byte and the current DIVISOR, go to START.
  - START: tx=0 for DIV+1 clocks, then DATA.
  - DATA: bits 0..7 in order, each held DIV+1 clocks. A 3-bit index wraps after bit 7, then STOP.
  - STOP: tx=1 for DIV+1 clocks. At the end, if FIFO non-empty, pop and go to START on the same edge (no idle gap); else IDLE.
- DIVISOR writes mid-frame take effect at the next frame (latched at pop).
- tx_active = (state != IDLE).

## Timing
- Reset values:
  - tx=1, tx_busy=0, state IDLE, FIFO empty, overflow=0, DIVISOR=DIV_RESET.
  - rd_data/hit are combinational: STATUS reads 32'h0000_0002 after reset.
- Reset mid-frame: tx returns high on the reset edge. FIFO flushed, in-flight byte lost.
- Push at edge N: count/empty visible in STATUS during cycle N+1.
- A push into an idle, empty block pops at edge N+1. tx falls at the start of cycle N+2, so the start bit begins 2 clocks after the write cycle.
- Frame length: exactly 10×(DIV+1) clocks. Back-to-back frames are contiguous.
- Bit counter: 16-bit down-counter reloaded with the latched DIV; it advances the bit when it reaches 0.
- Read side effects: none. Reads never pop.

## Structure
- Package uart_pkg:
  - state enum (IDLE, START, DATA, STOP).
  - register offset localparams: OFF_TXDATA=0, OFF_STATUS=1, OFF_DIVISOR=2.
  - STATUS bit-position localparams.
- Sub-module sync_fifo:
  - parameterized WIDTH/DEPTH.
  - push/pop/full/empty/count, head data visible combinationally.
  - push-while-full accepted only with a simultaneous pop.
- Top level holds the address decode, register file, read mux and serializer FSM.

## Test plan
- Reset, then read STATUS -> rd_data=32'h0000_0002, tx=1, tx_busy=0. Read addr 32'h9000_0004 -> hit=0, rd_data=0.
- DIVISOR=3, write 8'hA5 -> tx low 4 clocks starting 2 clocks after the write. Then bits 1,0,1,0,0,1,0,1, 4 clocks each, then high 4 clocks. tx_busy drops at frame end (40 clocks).
- DIVISOR=1, write 3 bytes on consecutive cycles -> three contiguous 20-clock frames with no idle gap. STATUS count reads 1,2 then decreases.
- DIVISOR=100, write 10 bytes back-to-back into FIFO_DEPTH=8 -> the first is popped. Entries 2–9 fill the FIFO, the 10th is dropped, STATUS bit3=1. Writing 32'h8 to STATUS clears it.
- Write DIVISOR=0 -> reads back 1. Write DIVISOR=7 mid-frame -> current frame keeps the old period, next frame uses 8 clocks/bit.
- Assert reset during a DATA bit with 3 bytes queued -> tx=1 on the next edge. STATUS=32'h0000_0002, no further frames.
